tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_pkg.sv | 16 +
 rtl/tick_div.sv | 40 ++++
 rtl/tick_scheduler.sv | 102 ++++++++++
 tb/tb_tick_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared state encoding and default timebase constants for the tick scheduler.
package tick_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   localparam int unsigned DEF_PIX_DIV    = 4;
   localparam int unsigned DEF_SAMPLE_DIV = 100000;
   localparam int unsigned DEF_PERIOD_W   = 26;
   localparam int unsigned DEF_GAME_PER   = 50000000;
   localparam int unsigned MIN_PERIOD     = 2;

endpackage

// File: rtl/tick_div.sv
// Modulo counter with enable, clear and loadable period; emits a registered
// single-cycle strobe the cycle after the counter sits at period-1.
module tick_div #(
   parameter int unsigned W   = 8,
   parameter int unsigned DEF = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tick
);

   logic [W-1:0] cnt;
   logic [W-1:0] per;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         per  <= W'(DEF);
         tick <= 1'b0;
      end else if (load) begin
         per  <= load_val;
         cnt  <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (en && (cnt == per - W'(1))) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         if (en) cnt <= cnt + W'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// System timebase: free-running pixel and sample strobes plus a game tick
// gated by an IDLE/RUN/PAUSE controller with a configurable period.
module tick_scheduler
   import tick_pkg::*;
#(
   parameter int unsigned PIX_DIV    = DEF_PIX_DIV,
   parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
   parameter int unsigned PERIOD_W   = DEF_PERIOD_W,
   parameter int unsigned DEF_PERIOD = DEF_GAME_PER
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                pause_req,
   input  logic                cfg_valid,
   input  logic [PERIOD_W-1:0] cfg_period,
   output logic                cfg_ready,
   output logic                pix_tick,
   output logic                sample_tick,
   output logic                game_tick,
   output logic [7:0]          tick_count,
   output logic [1:0]          state
);

   localparam int unsigned PIX_W = $clog2(PIX_DIV + 1);
   localparam int unsigned SMP_W = $clog2(SAMPLE_DIV + 1);

   state_t              state_q;
   state_t              next_state;
   logic                xfer;
   logic [PERIOD_W-1:0] period_in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= next_state;
   end

   always_comb begin
      next_state = IDLE;
      case (state_q)
         IDLE:    next_state = run ? RUN : IDLE;
         RUN: begin
            if (!run)           next_state = IDLE;
            else if (pause_req) next_state = PAUSE;
            else                next_state = RUN;
         end
         PAUSE: begin
            if (!run)            next_state = IDLE;
            else if (!pause_req) next_state = RUN;
            else                 next_state = PAUSE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign state     = state_q;
   assign cfg_ready = (state_q == IDLE) || (state_q == PAUSE);
   assign xfer      = cfg_valid && cfg_ready;
   assign period_in = (cfg_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : cfg_period;

   tick_div #(.W(PIX_W), .DEF(PIX_DIV)) u_pix (
      .clk      (clk),
      .rst      (rst),
      .en       (1'b1),
      .clr      (1'b0),
      .load     (1'b0),
      .load_val ('0),
      .tick     (pix_tick)
   );

   tick_div #(.W(SMP_W), .DEF(SAMPLE_DIV)) u_sample (
      .clk      (clk),
      .rst      (rst),
      .en       (1'b1),
      .clr      (1'b0),
      .load     (1'b0),
      .load_val ('0),
      .tick     (sample_tick)
   );

   // Enable follows the registered state, so a wrap on the last RUN cycle still strobes.
   tick_div #(.W(PERIOD_W), .DEF(DEF_PERIOD)) u_game (
      .clk      (clk),
      .rst      (rst),
      .en       (state_q == RUN),
      .clr      (state_q == IDLE),
      .load     (xfer),
      .load_val (period_in),
      .tick     (game_tick)
   );

   // Held at zero throughout IDLE so a trailing tick from the final wrap is not counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tick_count <= '0;
      else if ((state_q == IDLE) || (next_state == IDLE))
         tick_count <= '0;
      else if (game_tick)
         tick_count <= tick_count + 8'd1;
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler with small divide ratios.
module tb_tick_scheduler;

   localparam int unsigned PW = 26;

   logic          clk        = 1'b0;
   logic          rst        = 1'b0;
   logic          run        = 1'b0;
   logic          pause_req  = 1'b0;
   logic          cfg_valid  = 1'b0;
   logic [PW-1:0] cfg_period = '0;
   logic          cfg_ready;
   logic          pix_tick;
   logic          sample_tick;
   logic          game_tick;
   logic [7:0]    tick_count;
   logic [1:0]    state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tick_scheduler #(
      .PIX_DIV    (4),
      .SAMPLE_DIV (5),
      .PERIOD_W   (PW),
      .DEF_PERIOD (12)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .pause_req   (pause_req),
      .cfg_valid   (cfg_valid),
      .cfg_period  (cfg_period),
      .cfg_ready   (cfg_ready),
      .pix_tick    (pix_tick),
      .sample_tick (sample_tick),
      .game_tick   (game_tick),
      .tick_count  (tick_count),
      .state       (state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pix"},    32'(pix_tick),    32'd0);
      chk({tag, "_sample"}, 32'(sample_tick), 32'd0);
      chk({tag, "_game"},   32'(game_tick),   32'd0);
      chk({tag, "_count"},  32'(tick_count),  32'd0);
      chk({tag, "_state"},  32'(state),       32'd0);
      chk({tag, "_ready"},  32'(cfg_ready),   32'd1);
   endtask

   initial begin
      // Reset values and free-running strobes after release
      repeat (2) @(negedge clk);
      chk_reset("rst");
      rst = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         chk("pix_free",   32'(pix_tick),    32'(i % 4 == 0));
         chk("sample",     32'(sample_tick), 32'(i % 5 == 0));
         chk("game_idle",  32'(game_tick),   32'd0);
         chk("state_idle", 32'(state),       32'd0);
      end

      // Load period 10 in IDLE, then run
      cfg_valid  = 1'b1;
      cfg_period = PW'(10);
      chk("ready_idle", 32'(cfg_ready), 32'd1);
      @(negedge clk);
      cfg_valid = 1'b0;
      run       = 1'b1;

      @(negedge clk);  // k=1
      chk("state_run", 32'(state),     32'd1);
      chk("ready_run", 32'(cfg_ready), 32'd0);
      chk("game_k1",   32'(game_tick), 32'd0);
      for (int k = 2; k <= 31; k++) begin
         @(negedge clk);
         chk("game_p10", 32'(game_tick), 32'(k >= 11 && (k - 11) % 10 == 0));
      end
      @(negedge clk);  // k=32
      chk("count3", 32'(tick_count), 32'd3);

      // Offer in RUN must be ignored
      cfg_valid  = 1'b1;
      cfg_period = PW'(3);
      chk("ready_run_offer", 32'(cfg_ready), 32'd0);
      for (int k = 33; k <= 36; k++) begin
         @(negedge clk);
         chk("game_ignored_cfg", 32'(game_tick), 32'd0);
         chk("ready_run_hold",   32'(cfg_ready), 32'd0);
      end
      cfg_valid = 1'b0;
      @(negedge clk);  // k=37, counter=6
      chk("game_k37", 32'(game_tick), 32'd0);
      pause_req = 1'b1;

      for (int k = 38; k <= 57; k++) begin
         @(negedge clk);
         chk("game_paused",  32'(game_tick), 32'd0);
         chk("state_paused", 32'(state),     32'd2);
         chk("ready_paused", 32'(cfg_ready), 32'd1);
      end
      pause_req = 1'b0;
      @(negedge clk);  // k=58
      chk("state_resume", 32'(state),     32'd1);
      chk("game_k58",     32'(game_tick), 32'd0);
      @(negedge clk);
      chk("game_k59", 32'(game_tick), 32'd0);
      @(negedge clk);
      chk("game_k60", 32'(game_tick), 32'd0);
      @(negedge clk);
      chk("game_resume_tick", 32'(game_tick), 32'd1);
      @(negedge clk);  // k=62
      chk("count4", 32'(tick_count), 32'd4);
      pause_req = 1'b1;

      @(negedge clk);  // k=63: offer period 1 in PAUSE
      chk("state_pause2", 32'(state),     32'd2);
      chk("game_k63",     32'(game_tick), 32'd0);
      chk("ready_pause2", 32'(cfg_ready), 32'd1);
      cfg_valid  = 1'b1;
      cfg_period = PW'(1);
      @(negedge clk);  // k=64
      cfg_valid = 1'b0;
      pause_req = 1'b0;
      for (int k = 65; k <= 71; k++) begin
         @(negedge clk);
         chk("game_p2", 32'(game_tick), 32'(k >= 67 && (k % 2 == 1)));
      end
      @(negedge clk);  // k=72, counter=period-1
      chk("count7",  32'(tick_count), 32'd7);
      chk("game_k72", 32'(game_tick), 32'd0);
      run = 1'b0;

      @(negedge clk);  // k=73: final tick, already IDLE
      chk("final_tick",  32'(game_tick),  32'd1);
      chk("final_state", 32'(state),      32'd0);
      chk("final_count", 32'(tick_count), 32'd0);
      @(negedge clk);  // k=74
      chk("after_game",  32'(game_tick),  32'd0);
      chk("after_count", 32'(tick_count), 32'd0);
      run = 1'b1;

      @(negedge clk);
      chk("rerun_state", 32'(state),     32'd1);
      chk("game_k75",    32'(game_tick), 32'd0);
      @(negedge clk);
      chk("game_k76", 32'(game_tick), 32'd0);
      @(negedge clk);  // k=77
      chk("game_before_rst", 32'(game_tick), 32'd1);

      // Asynchronous reset mid-RUN, with run still high
      rst = 1'b0;
      #1;
      chk_reset("async");
      repeat (3) begin
         @(negedge clk);
         chk_reset("held");
      end
      rst = 1'b1;
      run = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk("pix_rerelease",  32'(pix_tick),  32'(i % 4 == 0));
         chk("game_rerelease", 32'(game_tick), 32'd0);
      end

      // Default period restored by reset
      run = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         chk("game_default", 32'(game_tick), 32'(k == 13));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
